matmul_byte_bus_slave: RTL and testbench

//  Byte-addressed responder for the host matrix bus (addr/data_in/data_out/write_en/read_en/start).

---
 rtl/matmul_byte_bus_slave.sv | 163 ++++++++++++++++
 tb/tb_matmul_byte_bus_slave.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/matmul_byte_bus_slave.sv
// Byte-addressed bus endpoint holding 4x4 A (16-bit), B (8-bit) and C (32-bit) matrices.
// Computes C = A x B sequentially, one multiply-accumulate per clock.
module matmul_byte_bus_slave #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned N      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data_in,
  input  logic              write_en,
  input  logic              read_en,
  output logic [7:0]        data_out,
  input  logic              start,
  output logic              ready,
  output logic              done
);

  localparam int unsigned NN   = N * N;
  localparam int unsigned IdxW = $clog2(N);

  localparam logic [ADDR_W-1:0] BBase  = ADDR_W'(8'h20);
  localparam logic [ADDR_W-1:0] CBase  = ADDR_W'(8'h30);
  localparam logic [ADDR_W-1:0] StAddr = ADDR_W'(8'h70);
  localparam logic [IdxW-1:0]   IdxMax = IdxW'(N - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
  logic [25:0]       acc_q, acc_d;
  logic [15:0]       a_q [NN];
  logic [15:0]       a_d [NN];
  logic [7:0]        b_q [NN];
  logic [7:0]        b_d [NN];
  logic [31:0]       c_q [NN];
  logic [31:0]       c_d [NN];
  logic [7:0]        data_out_q, data_out_d;
  logic              ready_q, ready_d, done_q, done_d;

  logic [23:0]       prod;
  logic [25:0]       sum;
  logic [7:0]        rd_byte;
  logic [ADDR_W-1:0] c_off;
  logic [31:0]       c_word;

  assign data_out = data_out_q;
  assign ready    = ready_q;
  assign done     = done_q;

  always_comb begin
    c_off   = addr - CBase;
    c_word  = c_q[c_off[5:2]];
    rd_byte = 8'h00;
    if (addr < BBase) begin
      rd_byte = addr[0] ? a_q[addr[4:1]][15:8] : a_q[addr[4:1]][7:0];
    end else if (addr < CBase) begin
      rd_byte = b_q[addr[3:0]];
    end else if (addr < StAddr) begin
      unique case (c_off[1:0])
        2'd0:    rd_byte = c_word[7:0];
        2'd1:    rd_byte = c_word[15:8];
        2'd2:    rd_byte = c_word[23:16];
        default: rd_byte = c_word[31:24];
      endcase
    end else if (addr == StAddr) begin
      rd_byte = {6'b0, done_q, ready_q};
    end
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    acc_d      = acc_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    data_out_d = data_out_q;
    ready_d    = ready_q;
    done_d     = done_q;

    prod = {8'b0, a_q[{i_q, k_q}]} * {16'b0, b_q[{k_q, j_q}]};
    sum  = acc_q + {2'b0, prod};

    // Operand writes only land while ready, so BUSY sees frozen A/B.
    if (write_en && ready_q) begin
      if (addr < BBase) begin
        if (addr[0]) a_d[addr[4:1]][15:8] = data_in;
        else         a_d[addr[4:1]][7:0]  = data_in;
      end else if (addr < CBase) begin
        b_d[addr[3:0]] = data_in;
      end
    end

    if (read_en && !write_en) data_out_d = rd_byte;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StBusy;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          ready_d = 1'b0;
          done_d  = 1'b0;
        end
      end
      StBusy: begin
        k_d = k_q + 1'b1;
        if (k_q == IdxMax) begin
          c_d[{i_q, j_q}] = {6'b0, sum};
          acc_d = '0;
          j_d   = j_q + 1'b1;
          if (j_q == IdxMax) begin
            i_d = i_q + 1'b1;
            if (i_q == IdxMax) begin
              state_d = StDone;
              ready_d = 1'b1;
              done_d  = 1'b1;
            end
          end
        end else begin
          acc_d = sum;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      data_out_q <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      for (int n = 0; n < NN; n++) begin
        a_q[n] <= '0;
        b_q[n] <= '0;
        c_q[n] <= '0;
      end
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
    end
  end

endmodule

// File: tb/tb_matmul_byte_bus_slave.sv
// Scoreboard bench for matmul_byte_bus_slave: reads push expected bytes, a monitor checks data_out.
module tb_matmul_byte_bus_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] data_in = '0;
  logic       write_en = 1'b0;
  logic       read_en = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data_out;
  logic       ready;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] val;
    string      name;
  } exp_t;
  exp_t sb[$];

  matmul_byte_bus_slave #(.ADDR_W(7), .N(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .data_in  (data_in),
    .write_en (write_en),
    .read_en  (read_en),
    .data_out (data_out),
    .start    (start),
    .ready    (ready),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // data_out is valid one edge after the read strobe is sampled.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (rst_n && read_en && !write_en) begin
        #1;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read actual=%0h required=none", data_out);
        end else begin
          e = sb.pop_front();
          check(e.name, {24'b0, data_out}, {24'b0, e.val});
        end
      end
    end
  end

  // All bus tasks enter and leave on a falling edge.
  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    addr = a; data_in = d; write_en = 1'b1;
    @(negedge clk);
    write_en = 1'b0;
  endtask

  task automatic rd(input logic [6:0] a, input logic [7:0] exp);
    exp_t e;
    e.val  = exp;
    e.name = $sformatf("rd_%02h", a);
    addr = a; read_en = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    read_en = 1'b0;
  endtask

  task automatic wr_a(input int i, input int j, input logic [15:0] v);
    wr(7'(2 * (4 * i + j)), v[7:0]);
    wr(7'(2 * (4 * i + j) + 1), v[15:8]);
  endtask

  task automatic rd_c(input int i, input int j, input logic [31:0] v);
    for (int b = 0; b < 4; b++) rd(7'(8'h30 + 4 * (4 * i + j) + b), v[8*b +: 8]);
  endtask

  task automatic run(input bit disturb, input string name);
    int n;
    int bad_ready;
    n = 0;
    bad_ready = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (disturb && c == 3) begin
        addr = 7'h00; data_in = 8'h09; write_en = 1'b1; start = 1'b1;
      end
      @(posedge clk);
      n++;
      #1;
      if (done) break;
      if (ready) bad_ready++;
      @(negedge clk);
      write_en = 1'b0;
      start = 1'b0;
    end
    @(negedge clk);
    write_en = 1'b0;
    start = 1'b0;
    check({name, "_done_latency"}, n, 64);
    check({name, "_ready_low_busy"}, bad_ready, 0);
    check({name, "_ready_at_done"}, {31'b0, ready}, 1);
  endtask

  task automatic load_s2();
    wr_a(0, 0, 16'h0001);
    wr_a(0, 1, 16'h0001);
    wr(7'h20, 8'h02);
    wr(7'h24, 8'h03);
  endtask

  task automatic check_s2();
    rd_c(0, 0, 32'h0000_0005);
    rd_c(0, 1, 32'h0);
    rd_c(0, 2, 32'h0);
    rd(7'h70, 8'h03);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_ready", {31'b0, ready}, 1);
    check("reset_done", {31'b0, done}, 0);
    check("reset_data_out", {24'b0, data_out}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: reset contents
    rd(7'h70, 8'h01);
    for (int n = 0; n < 16; n++) rd_c(n / 4, n % 4, 32'h0);
    rd(7'h75, 8'h00);

    // 2: small product
    load_s2();
    rd(7'h01, 8'h00);
    rd(7'h02, 8'h01);
    rd(7'h24, 8'h03);
    run(1'b0, "s2");
    check_s2();

    // 5: write and start during BUSY are ignored
    run(1'b1, "s5");
    check_s2();
    rd(7'h00, 8'h01);

    // 3: identity times counting B
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        wr_a(i, j, (i == j) ? 16'h0001 : 16'h0000);
        wr(7'(8'h20 + 4 * i + j), 8'(4 * i + j + 1));
      end
    wr(7'h38, 8'hAA);
    wr(7'h70, 8'hAA);
    run(1'b0, "s3");
    for (int n = 0; n < 16; n++) rd_c(n / 4, n % 4, 32'(n + 1));

    // 4: maximum operands
    for (int n = 0; n < 16; n++) begin
      wr_a(n / 4, n % 4, 16'hFFFF);
      wr(7'(8'h20 + n), 8'hFF);
    end
    run(1'b0, "s4");
    for (int n = 0; n < 16; n++) rd_c(n / 4, n % 4, 32'h03FB_FC04);
    rd(7'h7F, 8'h00);

    // 6: reset 20 clocks into BUSY aborts and clears
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("s6_busy_ready", {31'b0, ready}, 0);
    rst_n = 1'b0;
    #1;
    check("s6_rst_ready", {31'b0, ready}, 1);
    check("s6_rst_done", {31'b0, done}, 0);
    check("s6_rst_data_out", {24'b0, data_out}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(7'h70, 8'h01);
    for (int n = 0; n < 16; n++) rd_c(n / 4, n % 4, 32'h0);
    load_s2();
    run(1'b0, "s6");
    check_s2();

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
